// File: rtl/eth_decap.sv
// eth_decap: receive-side TLP-over-Ethernet decapsulator (clk156 domain).
// Consumes the 64-bit MAC RX AXI4-Stream, validates the 16-byte header
// (destination MAC + EtherType), strips it, and writes 83-bit TLP records
// {err, ch, tlast, tuser[7:0], tkeep[7:0], tdata[63:0]} into the eth2pcie FIFO.
// Ports:
//   clk156, sys_rst_n             clock, async active-low reset
//   s_axis_rx_*                   MAC RX stream (no backpressure)
//   wr_en, din                    registered FIFO write strobe and record
//   full                          FIFO prog_full (>=2 entries still free)
//   frm_ok_cnt/drop_cnt/err_cnt   wrap-around statistics counters
module eth_decap #(
  parameter logic [15:0] ETH_TYPE   = 16'h88B5,
  parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
  parameter logic        MAC_FILTER = 1'b1
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  input  logic        s_axis_rx_tvalid,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tlast,
  input  logic        s_axis_rx_tuser,
  output logic        wr_en,
  output logic [82:0] din,
  input  logic        full,
  output logic [31:0] frm_ok_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] err_cnt
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    DISCARD,
    DISCARD_T,
    TERM
  } state_t;

  // Destination MAC as it appears on the wire: address byte 0 sits in tdata[7:0].
  localparam logic [47:0] MAC_WIRE = {MAC_ADDR[7:0],   MAC_ADDR[15:8],
                                      MAC_ADDR[23:16], MAC_ADDR[31:24],
                                      MAC_ADDR[39:32], MAC_ADDR[47:40]};

  state_t      state;
  logic        dst_ok;
  logic        ch_q;
  logic [7:0]  tuser_q;
  logic        term_skip;  // in TERM: a frame has started and its tail must be swallowed

  logic        dst_hit;
  logic        type_hit;
  logic        term_skip_nxt;

  always_comb begin
    dst_hit = 1'b0;
    if (!MAC_FILTER)
      dst_hit = 1'b1;
    else if (s_axis_rx_tdata[47:0] == MAC_WIRE || s_axis_rx_tdata[47:0] == '1)
      dst_hit = 1'b1;
  end

  // EtherType is big-endian: tdata[39:32] carries the high byte.
  always_comb begin
    type_hit = ({s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]} == ETH_TYPE);
  end

  // Frame boundaries seen while waiting in TERM: every valid beat leaves us
  // mid-frame unless it is a tlast. TERM is only entered right after a tlast,
  // so term_skip=0 there means the next beat is a frame's beat 0.
  always_comb begin
    term_skip_nxt = term_skip;
    if (s_axis_rx_tvalid)
      term_skip_nxt = !s_axis_rx_tlast;
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= HDR0;
      dst_ok     <= 1'b0;
      ch_q       <= 1'b0;
      tuser_q    <= '0;
      term_skip  <= 1'b0;
      wr_en      <= 1'b0;
      din        <= '0;
      frm_ok_cnt <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        HDR0: begin
          if (s_axis_rx_tvalid) begin
            if (s_axis_rx_tlast) begin
              drop_cnt <= drop_cnt + 32'd1;
            end else begin
              dst_ok <= dst_hit;
              state  <= HDR1;
            end
          end
        end

        HDR1: begin
          if (s_axis_rx_tvalid) begin
            if (!(dst_ok && type_hit)) begin
              drop_cnt <= drop_cnt + 32'd1;
              state    <= s_axis_rx_tlast ? HDR0 : DISCARD;
            end else if (s_axis_rx_tlast) begin
              drop_cnt <= drop_cnt + 32'd1;
              state    <= HDR0;
            end else begin
              ch_q    <= s_axis_rx_tdata[48];
              tuser_q <= s_axis_rx_tdata[63:56];
              state   <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (s_axis_rx_tvalid) begin
            if (full) begin
              drop_cnt <= drop_cnt + 32'd1;
              state    <= s_axis_rx_tlast ? TERM : DISCARD_T;
            end else begin
              wr_en <= 1'b1;
              din   <= {s_axis_rx_tlast & ~s_axis_rx_tuser, ch_q, s_axis_rx_tlast,
                        tuser_q, s_axis_rx_tkeep, s_axis_rx_tdata};
              if (s_axis_rx_tlast) begin
                if (s_axis_rx_tuser)
                  frm_ok_cnt <= frm_ok_cnt + 32'd1;
                else
                  err_cnt <= err_cnt + 32'd1;
                state <= HDR0;
              end
            end
          end
        end

        DISCARD: begin
          if (s_axis_rx_tvalid && s_axis_rx_tlast)
            state <= HDR0;
        end

        DISCARD_T: begin
          if (s_axis_rx_tvalid && s_axis_rx_tlast)
            state <= TERM;
        end

        TERM: begin
          if (s_axis_rx_tvalid && !term_skip)
            drop_cnt <= drop_cnt + 32'd1;
          term_skip <= term_skip_nxt;
          if (!full) begin
            wr_en     <= 1'b1;
            din       <= {1'b1, ch_q, 1'b1, tuser_q, 8'h00, 64'h0};
            term_skip <= 1'b0;
            // A frame caught half-way through keeps being swallowed in DISCARD.
            state     <= term_skip_nxt ? DISCARD : HDR0;
          end
        end

        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_decap.sv
// tb_eth_decap: table-driven directed bench for eth_decap. Each vector is one
// clock of stimulus plus the wr_en/din expected after that clock's edge.
module tb_eth_decap;

  logic        clk156 = 1'b0;
  logic        sys_rst_n;
  logic        tvalid;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        full;
  logic        wr_en;
  logic [82:0] din;
  logic [31:0] frm_ok_cnt, drop_cnt, err_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned writes = 0;

  always #5 clk156 = ~clk156;

  eth_decap #(
    .ETH_TYPE  (16'h88B5),
    .MAC_ADDR  (48'h02_00_00_00_00_01),
    .MAC_FILTER(1'b1)
  ) dut (
    .clk156          (clk156),
    .sys_rst_n       (sys_rst_n),
    .s_axis_rx_tvalid(tvalid),
    .s_axis_rx_tdata (tdata),
    .s_axis_rx_tkeep (tkeep),
    .s_axis_rx_tlast (tlast),
    .s_axis_rx_tuser (tuser),
    .wr_en           (wr_en),
    .din             (din),
    .full            (full),
    .frm_ok_cnt      (frm_ok_cnt),
    .drop_cnt        (drop_cnt),
    .err_cnt         (err_cnt)
  );

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    logic        f;
    logic        ew;
    logic [82:0] ed;
    logic [82:0] em;
  } vec_t;

  vec_t vq[$];

  // Wire-order destination fields (address byte 0 in bits [7:0]).
  localparam logic [47:0] DST_OWN   = 48'h01_00_00_00_00_02;
  localparam logic [47:0] DST_BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] DST_OTHER = 48'h99_00_00_00_00_02;
  localparam logic [82:0] ALL       = '1;
  // err, tlast, tkeep and tdata of a record
  localparam logic [82:0] TERM_MASK = {1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF};

  function automatic logic [82:0] rec(input logic e, input logic c, input logic l,
                                      input logic [7:0] u, input logic [7:0] k,
                                      input logic [63:0] d);
    return {e, c, l, u, k, d};
  endfunction

  function automatic void add(input logic [63:0] d, input logic [7:0] k, input logic l,
                              input logic u, input logic f, input logic ew,
                              input logic [82:0] ed, input logic [82:0] em);
    vec_t x;
    x.v = 1'b1; x.d = d; x.k = k; x.l = l; x.u = u; x.f = f;
    x.ew = ew; x.ed = ed; x.em = em;
    vq.push_back(x);
  endfunction

  function automatic void idle(input logic f);
    vec_t x;
    x.v = 1'b0; x.d = '0; x.k = '0; x.l = 1'b0; x.u = 1'b0; x.f = f;
    x.ew = 1'b0; x.ed = '0; x.em = '0;
    vq.push_back(x);
  endfunction

  function automatic logic [63:0] hdr1(input logic [15:0] et, input logic c, input logic [7:0] u);
    return {u, 7'b0, c, et[7:0], et[15:8], 32'h5555_5555};
  endfunction

  // Accepted frame with n payload beats (n>=1); last beat has tkeep lk and FCS flag fcs.
  function automatic void good_frame(input logic [47:0] dst, input logic c, input logic [7:0] u,
                                     input int unsigned n, input logic [7:0] lk,
                                     input logic fcs, input logic [7:0] tag);
    logic [63:0] d;
    logic        last;
    logic [7:0]  k;
    add({16'hAAAA, dst}, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(hdr1(16'h88B5, c, u), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int unsigned i = 0; i < n; i++) begin
      d    = {8'hD0, tag, 16'h0000, 24'h0, i[7:0]};
      last = (i == n - 1);
      k    = last ? lk : 8'hFF;
      add(d, k, last, last & fcs, 1'b0, 1'b1, rec(last & ~fcs, c, last, u, k, d), ALL);
    end
  endfunction

  task automatic chk(input string name, input logic [82:0] act, input logic [82:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    tvalid = x.v; tdata = x.d; tkeep = x.k; tlast = x.l; tuser = x.u; full = x.f;
  endtask

  task automatic run(input string tag);
    for (int unsigned i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(negedge clk156);
      if (wr_en === 1'b1) writes++;
      chk($sformatf("%s[%0d].wr_en", tag, i), {82'b0, wr_en}, {82'b0, vq[i].ew});
      if (vq[i].ew)
        chk($sformatf("%s[%0d].din", tag, i), din & vq[i].em, vq[i].ed & vq[i].em);
    end
    vq.delete();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; full = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] ok, input logic [31:0] dr,
                         input logic [31:0] er);
    chk({tag, ".frm_ok_cnt"}, {51'b0, frm_ok_cnt}, {51'b0, ok});
    chk({tag, ".drop_cnt"},   {51'b0, drop_cnt},   {51'b0, dr});
    chk({tag, ".err_cnt"},    {51'b0, err_cnt},    {51'b0, er});
  endtask

  initial begin
    sys_rst_n = 1'b0;
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0; full = 1'b0;
    repeat (3) @(negedge clk156);
    sys_rst_n = 1'b1;
    @(negedge clk156);
    chk("reset.wr_en", {82'b0, wr_en}, '0);
    chk("reset.din", din, '0);
    chk_cnt("reset", 32'd0, 32'd0, 32'd0);

    // Good frame, bubble in the payload, partial last beat.
    good_frame(DST_OWN, 1'b1, 8'h3C, 3, 8'h0F, 1'b1, 8'h01);
    vq.insert(3, vq[0]);
    vq[3].v = 1'b0; vq[3].l = 1'b0; vq[3].ew = 1'b0;
    run("good");
    chk_cnt("good", 32'd1, 32'd0, 32'd0);

    // Bad FCS on the last beat.
    good_frame(DST_OWN, 1'b1, 8'h3C, 3, 8'h0F, 1'b0, 8'h02);
    run("badfcs");
    chk_cnt("badfcs", 32'd1, 32'd0, 32'd1);

    // Wrong EtherType, wrong destination, 1-beat runt, then broadcast accepted.
    add({16'hAAAA, DST_OWN}, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(hdr1(16'h0800, 1'b1, 8'h3C), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(1'b0);
    add({16'hAAAA, DST_OTHER}, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(hdr1(16'h88B5, 1'b1, 8'h3C), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(64'h5555_6666_7777_8888, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    add({16'hAAAA, DST_OWN}, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    good_frame(DST_BCAST, 1'b0, 8'h00, 1, 8'hFF, 1'b1, 8'h03);
    run("filter");
    chk_cnt("filter", 32'd2, 32'd3, 32'd1);

    // full on payload beat 2 of 4, then a frame arriving during TERM.
    add({16'hAAAA, DST_OWN}, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(hdr1(16'h88B5, 1'b1, 8'h3C), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(64'hC0C0_0000_0000_0000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1,
        rec(1'b0, 1'b1, 1'b0, 8'h3C, 8'hFF, 64'hC0C0_0000_0000_0000), ALL);
    add(64'hC0C0_0000_0000_0001, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    add(64'hC0C0_0000_0000_0002, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    add(64'hC0C0_0000_0000_0003, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    add({16'hAAAA, DST_OWN}, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    add(hdr1(16'h88B5, 1'b0, 8'h11), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1,
        rec(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 64'h0), TERM_MASK);
    add(64'hEEEE_0000_0000_0000, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    good_frame(DST_OWN, 1'b0, 8'h5A, 1, 8'h01, 1'b1, 8'h04);
    run("term");
    chk_cnt("term", 32'd3, 32'd5, 32'd1);

    // Ten back-to-back frames, no idle beats.
    for (int unsigned f = 0; f < 10; f++)
      good_frame(DST_OWN, f[0], 8'h40 + f[7:0], 2, 8'hFF, 1'b1, 8'h10 + f[7:0]);
    writes = 0;
    run("b2b");
    chk("b2b.writes", {51'b0, writes}, 83'd20);
    chk_cnt("b2b", 32'd13, 32'd5, 32'd1);

    // Counter wrap.
    @(negedge clk156);
    force dut.frm_ok_cnt = 32'hFFFF_FFFF;
    @(negedge clk156);
    release dut.frm_ok_cnt;
    good_frame(DST_OWN, 1'b1, 8'h77, 1, 8'hFF, 1'b1, 8'h05);
    run("wrap");
    chk_cnt("wrap", 32'd0, 32'd5, 32'd1);

    // Reset pulsed mid-payload.
    good_frame(DST_OWN, 1'b1, 8'h3C, 3, 8'hFF, 1'b1, 8'h06);
    void'(vq.pop_back());
    void'(vq.pop_back());
    run("rst_pre");
    sys_rst_n = 1'b0;
    #1;
    chk("rst.wr_en", {82'b0, wr_en}, '0);
    chk_cnt("rst", 32'd0, 32'd0, 32'd0);
    @(negedge clk156);
    sys_rst_n = 1'b1;
    add(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    add(64'h2222_2222_2222_2222, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    good_frame(DST_OWN, 1'b1, 8'h3C, 2, 8'h07, 1'b1, 8'h07);
    run("rst_post");
    chk_cnt("rst_post", 32'd1, 32'd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_decap.md
# eth_decap

Receive-side counterpart of the TLP-over-Ethernet encapsulation path. Consumes the 64-bit AXI4-Stream RX output of the 10G Ethernet MAC in the clk156 domain, validates and strips the 16-byte encapsulation header, and writes TLP records into the eth2pcie FIFO. Its record format mirrors the transmit arbiter's 83-bit format. No backpressure exists on the MAC side, so overflow and bad frames are handled by discard plus an error-marked terminating record.

## Interface
- ETH_TYPE, 16'h88B5: required EtherType.
- MAC_ADDR, 48'h02_00_00_00_00_01: local address; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- MAC_FILTER, 1: 1 = enforce the destination check, 0 = accept any destination.
- clk156  in  1  core clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- s_axis_rx_tvalid / tdata / tkeep / tlast / tuser  in  1/64/8/1/1  MAC RX stream; byte 0 at tdata[7:0]; tuser=1 on the tlast beat means good FCS.
- wr_en  out  1  FIFO write strobe (registered).
- din  out  83  {err, ch, tlast, tuser[7:0], tkeep[7:0], tdata[63:0]} (registered).
- full  in  1  FIFO prog_full; asserted with ≥2 free entries remaining.
- frm_ok_cnt, drop_cnt, err_cnt  out  32 each  wrap-around statistics counters.

## Operation
- Frame layout:
  - Beat 0 = dst MAC bytes 0-5, src bytes 0-1.
  - Beat 1 = src bytes 2-5; EtherType at bytes 12-13, big-endian (tdata[39:32] is the high byte); channel at byte 14 (bit 0 → ch); TLP tuser at byte 15.
  - Beats 2..N = TLP data, passed through unchanged with their tkeep.
- States:
  - HDR0: on a valid beat, check dst and go to HDR1. If tlast, count the frame as a drop and stay in HDR0.
  - HDR1: check EtherType and dst result.
    - Mismatch → DISCARD, or HDR0 with drop_cnt+1 if tlast.
    - Header-only frame (tlast here) → drop_cnt+1, HDR0, no record written.
    - Otherwise latch ch/tuser and go to PAYLOAD.
  - PAYLOAD: each beat with full=0 writes one record.
    - On tlast: record tlast=1 and err=~tuser; frm_ok_cnt+1 or err_cnt+1; go to HDR0.
    - Beat with full=1: no write, drop_cnt+1. If that beat is tlast go to TERM, else go to DISCARD_T.
  - DISCARD: swallow beats until tlast, then HDR0.
  - DISCARD_T: swallow beats until tlast, then TERM.
  - TERM: owes a terminating record {err=1, tlast=1, tkeep=0, tdata=0}, written on the first cycle full=0, then HDR0.
    - Any frame whose beat 0 arrives while in TERM is wholly discarded; drop_cnt+1 per such frame.
- A partial final beat passes its MAC tkeep unchanged. Bubbles (tvalid=0) are legal in any state and change nothing.
- Counters wrap from 32'hFFFFFFFF to 0. A single beat increments at most one counter.

## Timing
- Reset (async assert, sync release): state=HDR0, wr_en=0, din=0, all counters=0.
- Latency: a payload beat accepted at edge t produces wr_en=1 with its record on the cycle after edge t, one cycle only.
- Throughput: one record per clock with no bubbles. The ≥2-entry prog_full margin absorbs the registered write.
- Reset asserted mid-frame: the frame's remaining beats after release are discarded via DISCARD (HDR0 treats a non-header beat as a header). Downstream is reset together with this block.
- Simultaneous tlast and full=1 in PAYLOAD: no write this beat; TERM follows.

## Test plan
- Good frame, EtherType 88B5, dst=MAC_ADDR, ch=1, tuser=8'h3C, 3 payload beats, last tkeep=8'h0F:
  - 3 writes, last record tlast=1, err=0, ch=1, tuser=8'h3C, tkeep=8'h0F;
  - frm_ok_cnt=1.
- Same frame with FCS tuser=0 on the last beat → 3 writes, last record err=1; err_cnt=1.
- EtherType 0800, then dst=02:00:00:00:00:99 with MAC_FILTER=1, then a 1-beat runt → 0 writes; drop_cnt=3. A broadcast dst frame is accepted.
- full raised on payload beat 2 of 4 → 1 record written, then 1 terminating record {err=1, tlast=1, tkeep=0} after full drops; drop_cnt=1. A frame arriving during TERM is dropped; drop_cnt=2.
- Back-to-back 10 good frames with no idle beats → 10×N records with no gaps; frm_ok_cnt=10. Preset counter to 32'hFFFFFFFF → next good frame gives 0.
- sys_rst_n pulsed low mid-PAYLOAD → wr_en=0 and counters=0 immediately; trailing beats are discarded; next good frame decoded correctly.
